l1_msg_scheduler: RTL and testbench
===================================

// Module: l1_msg_scheduler
// PURPOSE
//  Sequences L2-to-L1 messages toward the L1 interface.
//  Two LLC-side requesters share one L1 message port:
//   - port A, fill path: GETLINE / SENDLINE
//   - port B, coherence path: INVALIDATELINE / EVICTLINE
//  Arbitrates with B priority plus an A starvation guard, queues winners in a FIFO,
//  and drains the FIFO over a valid/ready handshake gated by normal_mode.
// PARAMETERS
//  ADDR_W      32  address width
//  DEPTH       4   FIFO entries; power of two, >=2
//  MAX_STARVE  3   max consecutive B grants while A waits; range 1..15
// PORTS
//  clk          in   1              clock; all logic rising-edge
//  rst_n        in   1              asynchronous active-low reset
//  normal_mode  in   1              1: L1 port may issue; 0: issue suppressed
//  a_valid      in   1              port A request
//  a_ready      out  1              port A accepted this cycle
//  a_msg        in   3              port A message code
//  a_addr       in   ADDR_W         port A address
//  b_valid      in   1              port B request
//  b_ready      out  1              port B accepted this cycle
//  b_msg        in   3              port B message code
//  b_addr       in   ADDR_W         port B address
//  l1_valid     out  1              message at L1 port valid
//  l1_ready     in   1              L1 accepts message
//  l1_msg       out  3              issued message code
//  l1_addr      out  ADDR_W         issued address
//  fifo_count   out  clog2(DEPTH+1) current FIFO occupancy
//  err_illegal  out  1              one-cycle pulse: illegal code was accepted
//  illegal_cnt  out  8              saturating count of illegal codes
// BEHAVIOUR
//  Message codes:
//   - 1 GETLINE, 2 SENDLINE, 3 INVALIDATELINE, 4 EVICTLINE
//   - legal on A: 1, 2; legal on B: 3, 4; every other code/port pairing is illegal
//  Reset (rst_n=0, async):
//   - FIFO emptied; starve_cnt=0
//   - all outputs 0: a_ready, b_ready, l1_valid, l1_msg, l1_addr, fifo_count,
//     err_illegal, illegal_cnt
//   - reset mid-transfer drops l1_valid immediately; in-flight entries are lost
//  Arbitration (combinational; at most one grant per cycle; none when FIFO full):
//   - grant B if b_valid && (!a_valid || starve_cnt<MAX_STARVE)
//   - else grant A if a_valid
//   - a_ready / b_ready = the respective grant; a transfer occurs when valid&&ready
//  starve_cnt (4-bit):
//   - +1 when B granted while a_valid
//   - cleared when A granted or a_valid=0
//   - saturates at MAX_STARVE
//  Full FIFO:
//   - no grant even if the L1 side pops in the same cycle (no full-bypass)
//   - the popped slot is usable next cycle
//  Legal accepted request:
//   - {msg,addr} written at the FIFO tail on the accepting edge
//  Illegal accepted request:
//   - consumes the grant, updates starve_cnt normally, not written to the FIFO
//   - err_illegal=1 the following cycle only
//   - illegal_cnt +1, saturating at 255
//  Output:
//   - l1_valid = FIFO non-empty && normal_mode
//   - l1_msg / l1_addr = FIFO head, driven from registered storage
//   - l1_msg / l1_addr are held stable while l1_valid && !l1_ready
//   - pop on l1_valid && l1_ready
//  Latency: request accepted on edge N into an empty FIFO -> l1_valid high after edge N.
//  Simultaneous push and pop (FIFO not full):
//   - both take effect; fifo_count unchanged
//   - push/pop into an empty FIFO is not possible (no bypass)
//  normal_mode=0:
//   - l1_valid forced 0; queue retained; enqueue continues until full
//   - deassertion while l1_valid && !l1_ready withdraws the message; it is reissued later
//  Pointers: log2(DEPTH) bits, natural wrap. fifo_count is an explicit counter, 0..DEPTH.
// TESTING
//  T1 basic issue:
//     A sends GETLINE 0x0000_1000, l1_ready=1 -> l1_valid next cycle, l1_msg=1,
//     l1_addr=0x0000_1000; fifo_count 1 then 0.
//  T2 starvation guard:
//     a_valid and b_valid held high, l1_ready=1, MAX_STARVE=3 -> grant order
//     B,B,B,A,B,B,B,A.
//  T3 full FIFO:
//     l1_ready=0, 5 legal B requests, DEPTH=4 -> 4 accepted, b_ready=0 on the 5th,
//     fifo_count=4; raise l1_ready -> 5th accepted one cycle after the first pop.
//  T4 illegal codes:
//     A sends msg=3 and B sends msg=0 -> each handshake accepted, no FIFO write,
//     err_illegal pulses twice, illegal_cnt=2; saturation check at 255 after
//     260 illegal requests.
//  T5 normal_mode gating:
//     queue 2 entries with normal_mode=0 -> l1_valid=0, fifo_count=2; set
//     normal_mode=1 -> both entries issue in FIFO order.
//  T6 async reset mid-operation:
//     assert rst_n=0 mid-cycle with 3 entries queued and l1_valid=1 -> l1_valid
//     and fifo_count 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/l1_msg_scheduler_if.sv
// Request/issue bus between the two LLC-side requesters, the scheduler and the L1 message port.
// The slave modport is the scheduler's view; master is the view of whatever drives it.
interface l1_msg_scheduler_if #(
    parameter int ADDR_W = 32
);
    logic              a_valid;
    logic              a_ready;
    logic [2:0]        a_msg;
    logic [ADDR_W-1:0] a_addr;
    logic              b_valid;
    logic              b_ready;
    logic [2:0]        b_msg;
    logic [ADDR_W-1:0] b_addr;
    logic              l1_valid;
    logic              l1_ready;
    logic [2:0]        l1_msg;
    logic [ADDR_W-1:0] l1_addr;

    modport master (
        output a_valid, a_msg, a_addr, b_valid, b_msg, b_addr, l1_ready,
        input  a_ready, b_ready, l1_valid, l1_msg, l1_addr
    );

    modport slave (
        input  a_valid, a_msg, a_addr, b_valid, b_msg, b_addr, l1_ready,
        output a_ready, b_ready, l1_valid, l1_msg, l1_addr
    );
endinterface

// File: rtl/l1_msg_scheduler.sv
// Arbitrates fill (A) and coherence (B) messages into a FIFO and drains it to the L1 port.
// B has priority; A is guaranteed a grant after MAX_STARVE consecutive B wins.
module l1_msg_scheduler #(
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 4,
    parameter int MAX_STARVE = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_normal_mode,
    l1_msg_scheduler_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0] o_fifo_count,
    output logic                       o_err_illegal,
    output logic [7:0]                 o_illegal_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [2:0]        r_msg_mem  [DEPTH];
    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [3:0]        r_starve;
    logic              r_err;
    logic [7:0]        r_illegal_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_accept;
    logic              w_legal;
    logic              w_push;
    logic              w_pop;
    logic              w_l1_valid;
    logic [2:0]        w_in_msg;
    logic [ADDR_W-1:0] w_in_addr;

    // Grants are held off during reset so both ready outputs read 0 while rst_n is low.
    always_comb begin
        w_full     = (r_count == CNT_W'(DEPTH));
        w_empty    = (r_count == '0);
        w_grant_b  = i_rst_n && !w_full && bus.b_valid &&
                     (!bus.a_valid || (r_starve < 4'(MAX_STARVE)));
        w_grant_a  = i_rst_n && !w_full && bus.a_valid && !w_grant_b;
        w_accept   = w_grant_a || w_grant_b;
        w_in_msg   = w_grant_b ? bus.b_msg  : bus.a_msg;
        w_in_addr  = w_grant_b ? bus.b_addr : bus.a_addr;
        w_legal    = w_grant_b ? ((w_in_msg == 3'd3) || (w_in_msg == 3'd4))
                               : ((w_in_msg == 3'd1) || (w_in_msg == 3'd2));
        w_push     = w_accept && w_legal;
        w_l1_valid = !w_empty && i_normal_mode;
        w_pop      = w_l1_valid && bus.l1_ready;
    end

    assign bus.a_ready    = w_grant_a;
    assign bus.b_ready    = w_grant_b;
    assign bus.l1_valid   = w_l1_valid;
    // Head slot is never the write target while occupied, so this stays stable under backpressure.
    assign bus.l1_msg     = w_empty ? 3'd0 : r_msg_mem[r_rd_ptr];
    assign bus.l1_addr    = w_empty ? '0   : r_addr_mem[r_rd_ptr];
    assign o_fifo_count   = r_count;
    assign o_err_illegal  = r_err;
    assign o_illegal_cnt  = r_illegal_cnt;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_msg_mem[r_wr_ptr]  <= w_in_msg;
            r_addr_mem[r_wr_ptr] <= w_in_addr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A B grant while A waits is only possible below MAX_STARVE, which bounds the counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve <= '0;
        end else if (!bus.a_valid || w_grant_a) begin
            r_starve <= '0;
        end else if (w_grant_b) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err         <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_illegal_cnt != 8'hFF)) begin
                r_illegal_cnt <= r_illegal_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_l1_msg_scheduler.sv
// Bench for l1_msg_scheduler: directed scenarios plus randomized traffic against a queue-based model.
module tb_l1_msg_scheduler;
    localparam int ADDR_W     = 32;
    localparam int DEPTH      = 4;
    localparam int MAX_STARVE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       nm = 1'b0;
    logic [2:0] fifo_count;
    logic       err;
    logic [7:0] icnt;

    l1_msg_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    l1_msg_scheduler #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_STARVE(MAX_STARVE)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_normal_mode(nm), .bus(bus),
        .o_fifo_count(fifo_count), .o_err_illegal(err), .o_illegal_cnt(icnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the queue holds {msg, addr} of accepted legal messages in issue order.
    logic [34:0] mq [$];
    int          m_starve;
    int          m_icnt;
    bit          m_err;
    bit          e_ar, e_br, e_l1v;
    logic [2:0]  e_msg;
    logic [31:0] e_addr;

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_icnt   = 0;
        m_err    = 0;
    endtask

    task automatic model_eval();
        bit full;
        full  = (mq.size() == DEPTH);
        e_br  = !full && bus.b_valid && (!bus.a_valid || m_starve < MAX_STARVE);
        e_ar  = !full && bus.a_valid && !e_br;
        e_l1v = (mq.size() != 0) && nm;
        if (mq.size() != 0) {e_msg, e_addr} = mq[0];
        else begin e_msg = 3'd0; e_addr = 32'd0; end
    endtask

    task automatic model_commit();
        logic [2:0]  m;
        logic [31:0] ad;
        bit          lg;
        model_eval();
        if (e_l1v && bus.l1_ready) void'(mq.pop_front());
        m_err = 0;
        if (e_ar || e_br) begin
            m  = e_br ? bus.b_msg : bus.a_msg;
            ad = e_br ? bus.b_addr : bus.a_addr;
            lg = e_br ? (m == 3'd3 || m == 3'd4) : (m == 3'd1 || m == 3'd2);
            if (lg) mq.push_back({m, ad});
            else begin
                m_err = 1;
                if (m_icnt < 255) m_icnt++;
            end
        end
        if (!bus.a_valid || e_ar) m_starve = 0;
        else if (e_br) m_starve = (m_starve + 1 > MAX_STARVE) ? MAX_STARVE : m_starve + 1;
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.a_valid = 0; bus.a_msg = 3'd1; bus.a_addr = '0;
        bus.b_valid = 0; bus.b_msg = 3'd3; bus.b_addr = '0;
        bus.l1_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        set_idle();
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic drain();
        set_idle();
        nm = 1;
        bus.l1_ready = 1;
        for (int i = 0; i < 20 && fifo_count != 0; i++) tick();
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", fifo_count); end
    endtask

    task automatic test_reset();
        rst_n = 0;
        nm = 1;
        bus.a_valid = 1; bus.a_msg = 3'd1; bus.b_valid = 1; bus.b_msg = 3'd3; bus.l1_ready = 1;
        @(posedge clk);
        #1;
        checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready got %0b exp 0", bus.a_ready); end
        checks++; if (bus.b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready got %0b exp 0", bus.b_ready); end
        checks++; if (bus.l1_valid !== 1'b0) begin errors++; $display("FAIL rst_l1_valid got %0b exp 0", bus.l1_valid); end
        checks++; if (bus.l1_msg !== 3'd0) begin errors++; $display("FAIL rst_l1_msg got %0h exp 0", bus.l1_msg); end
        checks++; if (bus.l1_addr !== 32'd0) begin errors++; $display("FAIL rst_l1_addr got %0h exp 0", bus.l1_addr); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", err); end
        checks++; if (icnt !== 8'd0) begin errors++; $display("FAIL rst_icnt got %0d exp 0", icnt); end
        set_idle();
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_basic();
        nm = 1; bus.l1_ready = 1;
        bus.a_valid = 1; bus.a_msg = 3'd1; bus.a_addr = 32'h0000_1000;
        #1;
        checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL t1_a_ready got %0b exp 1", bus.a_ready); end
        tick();
        bus.a_valid = 0;
        #1;
        checks++; if (bus.l1_valid !== 1'b1) begin errors++; $display("FAIL t1_l1_valid got %0b exp 1", bus.l1_valid); end
        checks++; if (bus.l1_msg !== 3'd1) begin errors++; $display("FAIL t1_l1_msg got %0h exp 1", bus.l1_msg); end
        checks++; if (bus.l1_addr !== 32'h0000_1000) begin errors++; $display("FAIL t1_l1_addr got %0h exp 1000", bus.l1_addr); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL t1_count1 got %0d exp 1", fifo_count); end
        tick();
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL t1_count0 got %0d exp 0", fifo_count); end
        checks++; if (bus.l1_valid !== 1'b0) begin errors++; $display("FAIL t1_l1_idle got %0b exp 0", bus.l1_valid); end
    endtask

    task automatic test_starvation();
        logic [7:0] a_turn;
        a_turn = 8'b1000_1000;  // bit i set: cycle i grants A (order B,B,B,A,B,B,B,A)
        do_reset();
        nm = 1; bus.l1_ready = 1;
        bus.a_valid = 1; bus.a_msg = 3'd2; bus.a_addr = 32'hA000;
        bus.b_valid = 1; bus.b_msg = 3'd4; bus.b_addr = 32'hB000;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if ({bus.a_ready, bus.b_ready} !== {a_turn[i], !a_turn[i]}) begin
                errors++;
                $display("FAIL t2_grant%0d got a=%0b b=%0b exp a=%0b", i, bus.a_ready, bus.b_ready, a_turn[i]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_full();
        nm = 1; bus.l1_ready = 0;
        bus.b_valid = 1; bus.b_msg = 3'd3;
        for (int i = 0; i < 4; i++) begin
            bus.b_addr = 32'h100 + i;
            #1;
            checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL t3_fill%0d got %0b exp 1", i, bus.b_ready); end
            tick();
        end
        bus.b_addr = 32'h104;
        #1;
        checks++; if (bus.b_ready !== 1'b0) begin errors++; $display("FAIL t3_full_ready got %0b exp 0", bus.b_ready); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL t3_full_count got %0d exp 4", fifo_count); end
        checks++; if (bus.l1_addr !== 32'h100) begin errors++; $display("FAIL t3_head got %0h exp 100", bus.l1_addr); end
        tick();
        bus.l1_ready = 1;
        #1;
        checks++; if (bus.b_ready !== 1'b0) begin errors++; $display("FAIL t3_no_bypass got %0b exp 0", bus.b_ready); end
        tick();
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL t3_after_pop got %0b exp 1", bus.b_ready); end
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL t3_after_pop_cnt got %0d exp 3", fifo_count); end
        tick();
        bus.b_valid = 0;
        for (int j = 2; j <= 4; j++) begin
            #1;
            checks++; if (bus.l1_addr !== 32'h100 + j) begin errors++; $display("FAIL t3_order%0d got %0h exp %0h", j, bus.l1_addr, 32'h100 + j); end
            tick();
        end
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL t3_empty got %0d exp 0", fifo_count); end
    endtask

    task automatic test_illegal();
        do_reset();
        nm = 1; bus.l1_ready = 1;
        bus.a_valid = 1; bus.a_msg = 3'd3; bus.a_addr = 32'hDEAD;
        bus.b_valid = 1; bus.b_msg = 3'd0; bus.b_addr = 32'hBEEF;
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL t4_b_ready got %0b exp 1", bus.b_ready); end
        tick();
        bus.b_valid = 0;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t4_err1 got %0b exp 1", err); end
        checks++; if (icnt !== 8'd1) begin errors++; $display("FAIL t4_icnt1 got %0d exp 1", icnt); end
        checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL t4_a_ready got %0b exp 1", bus.a_ready); end
        tick();
        bus.a_valid = 0;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t4_err2 got %0b exp 1", err); end
        checks++; if (icnt !== 8'd2) begin errors++; $display("FAIL t4_icnt2 got %0d exp 2", icnt); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL t4_no_write got %0d exp 0", fifo_count); end
        tick();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t4_err_pulse got %0b exp 0", err); end
        bus.b_valid = 1; bus.b_msg = 3'd7;
        repeat (258) tick();
        bus.b_valid = 0;
        #1;
        checks++; if (icnt !== 8'd255) begin errors++; $display("FAIL t4_sat got %0d exp 255", icnt); end
        tick();
        #1;
        checks++; if (icnt !== 8'd255) begin errors++; $display("FAIL t4_sat_hold got %0d exp 255", icnt); end
    endtask

    task automatic test_normal_mode();
        nm = 0; bus.l1_ready = 1;
        bus.a_valid = 1; bus.a_msg = 3'd1; bus.a_addr = 32'hA0;
        tick();
        bus.a_msg = 3'd2; bus.a_addr = 32'hB0;
        tick();
        bus.a_valid = 0;
        #1;
        checks++; if (bus.l1_valid !== 1'b0) begin errors++; $display("FAIL t5_gated got %0b exp 0", bus.l1_valid); end
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL t5_count got %0d exp 2", fifo_count); end
        tick();
        nm = 1;
        #1;
        checks++; if ({bus.l1_valid, bus.l1_msg, bus.l1_addr} !== {1'b1, 3'd1, 32'hA0}) begin
            errors++; $display("FAIL t5_first got v=%0b m=%0h a=%0h exp v=1 m=1 a=a0", bus.l1_valid, bus.l1_msg, bus.l1_addr); end
        tick();
        #1;
        checks++; if ({bus.l1_valid, bus.l1_msg, bus.l1_addr} !== {1'b1, 3'd2, 32'hB0}) begin
            errors++; $display("FAIL t5_second got v=%0b m=%0h a=%0h exp v=1 m=2 a=b0", bus.l1_valid, bus.l1_msg, bus.l1_addr); end
        tick();
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL t5_empty got %0d exp 0", fifo_count); end
    endtask

    function automatic logic [2:0] pick_msg(bit port_b);
        if ($urandom_range(0, 9) == 0) return 3'($urandom_range(0, 7));
        return port_b ? 3'($urandom_range(3, 4)) : 3'($urandom_range(1, 2));
    endfunction

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.a_valid  = $urandom_range(0, 1) == 1;
            bus.a_msg    = pick_msg(0);
            bus.a_addr   = $urandom;
            bus.b_valid  = $urandom_range(0, 2) != 0;
            bus.b_msg    = pick_msg(1);
            bus.b_addr   = $urandom;
            bus.l1_ready = $urandom_range(0, 2) == 0;
            nm           = $urandom_range(0, 5) != 0;
            #1;
            model_eval();
            checks++; if (bus.a_ready !== e_ar) begin errors++; $display("FAIL rnd_a_ready cyc %0d got %0b exp %0b", i, bus.a_ready, e_ar); end
            checks++; if (bus.b_ready !== e_br) begin errors++; $display("FAIL rnd_b_ready cyc %0d got %0b exp %0b", i, bus.b_ready, e_br); end
            checks++; if (bus.l1_valid !== e_l1v) begin errors++; $display("FAIL rnd_l1_valid cyc %0d got %0b exp %0b", i, bus.l1_valid, e_l1v); end
            checks++; if ({bus.l1_msg, bus.l1_addr} !== {e_msg, e_addr}) begin
                errors++; $display("FAIL rnd_head cyc %0d got %0h/%0h exp %0h/%0h", i, bus.l1_msg, bus.l1_addr, e_msg, e_addr); end
            checks++; if (fifo_count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", i, fifo_count, mq.size()); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %0b exp %0b", i, err, m_err); end
            checks++; if (icnt !== 8'(m_icnt)) begin errors++; $display("FAIL rnd_icnt cyc %0d got %0d exp %0d", i, icnt, m_icnt); end
            tick();
        end
        drain();
    endtask

    task automatic test_async_reset();
        nm = 1; bus.l1_ready = 0;
        bus.b_valid = 1; bus.b_msg = 3'd4;
        for (int i = 0; i < 3; i++) begin
            bus.b_addr = 32'h300 + i;
            tick();
        end
        bus.b_valid = 0;
        #1;
        checks++; if ({bus.l1_valid, fifo_count} !== {1'b1, 3'd3}) begin
            errors++; $display("FAIL t6_pre got v=%0b cnt=%0d exp v=1 cnt=3", bus.l1_valid, fifo_count); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (bus.l1_valid !== 1'b0) begin errors++; $display("FAIL t6_l1_valid got %0b exp 0", bus.l1_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL t6_count got %0d exp 0", fifo_count); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        set_idle();
        test_reset();
        test_basic();
        test_starvation();
        test_full();
        test_illegal();
        test_normal_mode();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
